time_set_input: RTL
===================

Name: time_set_input

Overview:
- User-input front end for the clock design; drives the counter chain the opposite way from the display path (keys → counter value, rather than counter → segments).
- Synchronises and debounces two raw active-low push-buttons and generates press and auto-repeat events.
- Runs a digit-edit state machine over a BCD time snapshot and, on completion, presents the edited value with a one-cycle load strobe to the counter chain.
- While editing, it asserts a hold so the counters stop advancing.

Parameters:
DIGITS, 4, number of BCD digits edited (value width 4*DIGITS)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz)
REPEAT_DELAY, 25000000, cycles inc key must be held after its press event before first auto-repeat
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeats

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
key_mode_n  input  1  raw mode button, low = pressed, asynchronous to clock
key_inc_n  input  1  raw increment button, low = pressed, asynchronous to clock
counter_value  input  4*DIGITS  current BCD time from counter chain, digit 0 = LSBs
edit_active  output  1  high while in edit; counters must treat it as enable-low
digit_blink  output  DIGITS  one-hot mask of digit under edit; all zero outside edit
edit_value  output  4*DIGITS  working BCD value; shown instead of counter_value while edit_active
load  output  1  one-cycle strobe: counter chain loads edit_value

Behaviour:
- Reset (reset low, asynchronous):
  - FSM to RUN; edit_active=0, digit_blink=0, edit_value=0, load=0.
  - Synchronisers set to 1 (released); debounced levels = released; all counters 0.
  - Reset mid-edit discards the edit with no load.
- Input conditioning, per key:
  - 2-FF synchroniser produces sample s.
  - Debounced level d with counter cnt: if s==d then cnt=0; else cnt increments, and when cnt reaches DEBOUNCE_CYCLES-1, d<=s and cnt<=0.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
  - Press event = d transitions released→pressed. One event per transition.
  - With N=DEBOUNCE_CYCLES, the effect of a press appears at outputs after rising edge 3+N counted from the first edge that samples the new pin level.
- Auto-repeat (inc key only, EDIT only):
  - Hold counter starts at the press event.
  - First repeat event REPEAT_DELAY cycles after the press event, then one every REPEAT_PERIOD cycles while d stays pressed.
  - Hold counter clears on debounced release and in RUN.
- FSM states: RUN, EDIT, COMMIT.
  - RUN, mode press → EDIT:
    - edit_value <= counter_value (snapshot).
    - Current digit index k = DIGITS-1 (most significant).
    - edit_active=1; digit_blink=one-hot(k).
  - EDIT, inc press or repeat event:
    - Digit k of edit_value increments; 9 wraps to 0.
    - A digit value 10..15 (non-BCD snapshot) becomes 0.
    - Other digits unchanged.
  - EDIT, mode press:
    - k>0: k <= k-1.
    - k==0: → COMMIT.
  - COMMIT, exactly one cycle:
    - load=1, edit_value stable, edit_active=1, digit_blink=0.
    - Next cycle → RUN: edit_active=0, load=0; edit_value holds its last value.
- Events outside EDIT:
  - inc events in RUN are ignored.
  - Any events during the COMMIT cycle are ignored.
- Simultaneous mode and inc events in the same cycle: mode wins; inc is dropped.
- load is never asserted except in COMMIT; no load ever occurs without a full pass through all DIGITS digits.
- Outputs are registered; no combinational path from any key input to any output.

Test Plan:
Bench parameters: DIGITS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8.
- Reset/idle: reset low 3 cycles then high, keys high → edit_active=0, digit_blink=0000, edit_value=0, load=0; reset low asynchronously mid-cycle clears all immediately.
- Bounce rejection: key_mode_n low for 3 cycles, high 2, low 3, then high → no state change; a low pulse of 4+ cycles enters EDIT with digit_blink=1000.
- Full edit: counter_value=16'h1259; mode press; inc ×3; mode; mode; inc ×1; mode; mode:
  - edit_value goes 16'h4259, then 16'h4269.
  - The final mode press gives load=1 for exactly one cycle with edit_value=16'h4269.
  - Then edit_active=0.
- Wrap and non-BCD: snapshot 16'h9F00, inc on digit 3 → 16'h0F00; advance to digit 2, inc → 16'h0000.
- Auto-repeat: in EDIT digit 3 (value 0), hold key_inc_n low for press+40 cycles → press event then repeats at +16, +24, +32, +40 → digit 3 = 5; release stops increments.
- Simultaneous and abort:
  - Both presses land in the same cycle while on digit 3 → digit_blink=0100 and the digit value is unchanged.
  - Reset asserted while in EDIT → RUN with load never pulsing.

Source files
------------

// File: rtl/time_set_if.sv
// rtl/time_set_if.sv - counter-chain side bundle of the time-set front end
interface time_set_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] counter_value;
  logic                edit_active;
  logic [DIGITS-1:0]   digit_blink;
  logic [4*DIGITS-1:0] edit_value;
  logic                load;

  modport master (
    input  counter_value,
    output edit_active,
    output digit_blink,
    output edit_value,
    output load
  );

  modport slave (
    output counter_value,
    input  edit_active,
    input  digit_blink,
    input  edit_value,
    input  load
  );
endinterface

// File: rtl/time_set_input.sv
// rtl/time_set_input.sv - key debounce, auto-repeat and BCD digit-edit FSM
module time_set_input #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_mode_n,
  input  logic        key_inc_n,
  time_set_if.master  bus
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(RMAX + 1);
  localparam int KW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW   = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_RUN,
    S_EDIT,
    S_COMMIT
  } state_t;

  // Key index 0 = mode, 1 = inc; all levels active-low, 1 = released.
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_deb;
  logic [1:0]     r_press;
  logic [DBW-1:0] r_db_cnt [2];
  logic [1:0]     w_fall;

  logic [HW-1:0]  r_hold_cnt;
  logic           r_hold_on;
  logic           r_repeat;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [KW-1:0]  r_k;
  logic [KW-1:0]  w_k_nxt;
  logic [VW-1:0]  r_value;
  logic [VW-1:0]  w_value_nxt;
  logic [DIGITS-1:0] r_blink;
  logic [DIGITS-1:0] w_blink_nxt;
  logic           r_active;
  logic           w_active_nxt;
  logic           r_load;
  logic           w_load_nxt;
  logic [3:0]     w_digit;

  // A debounced released->pressed transition happens on this edge.
  always_comb begin
    w_fall = '0;
    for (int i = 0; i < 2; i++) begin
      w_fall[i] = (r_sync2[i] != r_deb[i]) && !r_sync2[i] &&
                  (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_deb   <= 2'b11;
      r_press <= 2'b00;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= {key_inc_n, key_mode_n};
      r_sync2 <= r_sync1;
      r_press <= w_fall;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Countdown from the press event; reloads with the period after each repeat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hold_cnt <= '0;
      r_hold_on  <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      if (w_fall[1] && (r_state == S_EDIT)) begin
        r_hold_on  <= 1'b1;
        r_hold_cnt <= HW'(REPEAT_DELAY - 1);
      end else if ((r_state != S_EDIT) || r_deb[1]) begin
        r_hold_on  <= 1'b0;
        r_hold_cnt <= '0;
      end else if (r_hold_on) begin
        if (r_hold_cnt == '0) begin
          r_repeat   <= 1'b1;
          r_hold_cnt <= HW'(REPEAT_PERIOD - 1);
        end else begin
          r_hold_cnt <= r_hold_cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_RUN;
      r_k      <= '0;
      r_value  <= '0;
      r_blink  <= '0;
      r_active <= 1'b0;
      r_load   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_value  <= w_value_nxt;
      r_blink  <= w_blink_nxt;
      r_active <= w_active_nxt;
      r_load   <= w_load_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_k_nxt      = r_k;
    w_value_nxt  = r_value;
    w_blink_nxt  = r_blink;
    w_active_nxt = r_active;
    w_load_nxt   = 1'b0;
    w_digit      = 4'd0;
    case (r_state)
      S_RUN: begin
        w_active_nxt = 1'b0;
        w_blink_nxt  = '0;
        if (r_press[0]) begin
          w_state_nxt  = S_EDIT;
          w_value_nxt  = bus.counter_value;
          w_k_nxt      = KW'(DIGITS - 1);
          w_active_nxt = 1'b1;
          w_blink_nxt  = {1'b1, {(DIGITS-1){1'b0}}};
        end
      end
      S_EDIT: begin
        if (r_press[0]) begin
          if (r_k == '0) begin
            w_state_nxt = S_COMMIT;
            w_load_nxt  = 1'b1;
            w_blink_nxt = '0;
          end else begin
            w_k_nxt     = r_k - 1'b1;
            w_blink_nxt = r_blink >> 1;
          end
        end else if (r_press[1] || r_repeat) begin
          // Non-BCD snapshot digits (10..15) fall into the 9->0 wrap.
          for (int d = 0; d < DIGITS; d++) begin
            if (KW'(d) == r_k) begin
              w_digit = r_value[4*d +: 4];
              w_value_nxt[4*d +: 4] = (w_digit >= 4'd9) ? 4'd0 : w_digit + 4'd1;
            end
          end
        end
      end
      S_COMMIT: begin
        w_state_nxt  = S_RUN;
        w_active_nxt = 1'b0;
      end
      default: begin
        w_state_nxt  = S_RUN;
        w_active_nxt = 1'b0;
        w_blink_nxt  = '0;
      end
    endcase
  end

  assign bus.edit_active = r_active;
  assign bus.digit_blink = r_blink;
  assign bus.edit_value  = r_value;
  assign bus.load        = r_load;

endmodule
